wb_arbiter2: RTL and testbench

Two-master, one-slave Wishbone (classic, non-pipelined) arbiter for the mips32r1 SoC. It shares a single slave port, such as on-chip memory or the peripheral bridge, between the instruction-fetch master (m0) and the data master (m1). It does this with round-robin fairness, cycle-granular locking on `cyc`, and a per-transfer timeout watchdog that terminates hung slave accesses with `err`. It sits between the core's Wishbone masters and the slave interconnect, clocked on the SoC clock.

---
 rtl/wb_arbiter2.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin tie breaking,
// cycle-locked grants and a per-transfer stall watchdog that forces err.
module wb_arbiter2 #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TO_W    = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   // master 0 (instruction fetch)
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AW-1:0]     m0_adr_i,
   input  logic [DW-1:0]     m0_dat_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   output logic [DW-1:0]     m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   // master 1 (data)
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AW-1:0]     m1_adr_i,
   input  logic [DW-1:0]     m1_dat_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   output logic [DW-1:0]     m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   // shared slave port
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   output logic [DW/8-1:0]   s_sel_o,
   input  logic [DW-1:0]     s_dat_i,
   input  logic              s_ack_i,
   input  logic              s_err_i
);

   localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              gnt_stb;
   logic              timeout;

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_stb = ((state_q == StGnt0) && m0_stb_i) || ((state_q == StGnt1) && m1_stb_i);
      timeout = gnt_stb && (TIMEOUT != 0) && (tcnt_q == TO_VAL);
      // Clearing on the timeout cycle keeps the counter from ever passing TIMEOUT.
      if (!gnt_stb || s_ack_i || s_err_i || timeout) begin
         tcnt_d = '0;
      end else begin
         tcnt_d = tcnt_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? StGnt0 : StGnt1;
            end else if (m0_cyc_i) begin
               state_d = StGnt0;
            end else if (m1_cyc_i) begin
               state_d = StGnt1;
            end
         end
         StGnt0: begin
            if (!m0_cyc_i) begin
               state_d = StIdle;
               last_d  = 1'b0;
            end
         end
         StGnt1: begin
            if (!m1_cyc_i) begin
               state_d = StIdle;
               last_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (state_q)
         StGnt0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i && !timeout;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            m0_ack_o = m0_stb_i && s_ack_i && !timeout;
            m0_err_o = m0_stb_i && (s_err_i || timeout);
         end
         StGnt1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i && !timeout;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            m1_ack_o = m1_stb_i && s_ack_i && !timeout;
            m1_err_o = m1_stb_i && (s_err_i || timeout);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: one instance with TIMEOUT=5, a twin with the
// watchdog disabled driven by the same stimulus.
module tb_wb_arbiter2;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_rdat, m1_rdat;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic [3:0]  s_sel;
   logic        s_ack, s_err;

   logic [31:0] z_m0_rdat, z_m1_rdat, z_s_adr, z_s_wdat;
   logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
   logic [3:0]  z_s_sel;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   wb_arbiter2 #(.AW(32), .DW(32), .TO_W(8), .TIMEOUT(5)) dut (
      .clock(clock), .reset(reset),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
      .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err)
   );

   wb_arbiter2 #(.AW(32), .DW(32), .TO_W(8), .TIMEOUT(0)) dut_z (
      .clock(clock), .reset(reset),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_dat_o(z_m0_rdat), .m0_ack_o(z_m0_ack),
      .m0_err_o(z_m0_err),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_dat_o(z_m1_rdat), .m1_ack_o(z_m1_ack),
      .m1_err_o(z_m1_err),
      .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_adr_o(z_s_adr),
      .s_dat_o(z_s_wdat), .s_sel_o(z_s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack),
      .s_err_i(s_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic probe();
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
      s_rdat = '0; s_ack = 0; s_err = 0;

      // Reset state
      step(); step(); probe();
      chk("rst_s_cyc", s_cyc, 0);
      chk("rst_s_stb", s_stb, 0);
      chk("rst_s_adr", s_adr, 0);
      chk("rst_m0_ack", m0_ack, 0);
      chk("rst_m1_err", m1_err, 0);

      // m0 single read, acked on the 2nd stalled cycle
      step(); reset = 0; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF;
      probe(); chk("t1_idle_cyc", s_cyc, 0);
      step(); probe();
      chk("t1_gnt_cyc", s_cyc, 1);
      chk("t1_adr", s_adr, 32'h100);
      chk("t1_stall_ack", m0_ack, 0);
      step(); s_ack = 1; s_rdat = 32'hDEADBEEF; probe();
      chk("t1_ack", m0_ack, 1);
      chk("t1_rdat", m0_rdat, 32'hDEADBEEF);
      chk("t1_m1_ack", m1_ack, 0);
      step(); s_ack = 0; m0_cyc = 0; m0_stb = 0; probe();
      chk("t1_ack_once", m0_ack, 0);
      step();

      // Simultaneous requests right after reset: m0 first, then m1
      reset = 1;
      step(); reset = 0;
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
      probe(); chk("t2_idle", s_cyc, 0);
      step(); s_ack = 1; probe();
      chk("t2_first_adr", s_adr, 32'h10);
      chk("t2_m0_ack", m0_ack, 1);
      chk("t2_m1_ack0", m1_ack, 0);
      step(); s_ack = 0; m0_cyc = 0; m0_stb = 0; probe();
      chk("t2_rel_cyc", s_cyc, 0);
      step(); probe(); chk("t2_dead", s_cyc, 0);
      step(); s_ack = 1; probe();
      chk("t2_second_adr", s_adr, 32'h20);
      chk("t2_m1_ack", m1_ack, 1);
      chk("t2_m0_ack0", m0_ack, 0);
      step(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
      step(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h30; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h40;
      probe(); chk("t2r_idle", s_cyc, 0);
      step(); s_ack = 1; probe();
      chk("t2r_first_adr", s_adr, 32'h30);
      chk("t2r_m0_ack", m0_ack, 1);
      step(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
      step(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300; m0_we = 0;
      probe(); chk("t3_idle", s_cyc, 0);

      // m1 locks the bus for four back-to-back writes while m0 waits
      for (int i = 0; i < 4; i++) begin
         step();
         m1_we = 1; m1_adr = 32'h200 + 32'(4 * i); m1_wdat = 32'hA0 + 32'(i); m1_sel = 4'h3;
         s_ack = 1;
         probe();
         chk("t3_w_adr", s_adr, 32'h200 + 32'(4 * i));
         chk("t3_w_dat", s_wdat, 32'hA0 + 32'(i));
         chk("t3_w_sel", s_sel, 4'h3);
         chk("t3_w_we", s_we, 1);
         chk("t3_m1_ack", m1_ack, 1);
         chk("t3_m0_ack", m0_ack, 0);
      end
      step(); s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; probe();
      chk("t3_rel_stb", s_stb, 0);
      chk("t3_rel_m0_ack", m0_ack, 0);
      step(); probe(); chk("t3_dead", s_cyc, 0);

      // m0 granted and the slave never answers: err on the 6th stalled cycle
      step(); probe();
      chk("t4_m0_adr", s_adr, 32'h300);
      chk("t4_stb", s_stb, 1);
      chk("t4_we", s_we, 0);
      chk("t4_err_s1", m0_err, 0);
      for (int k = 2; k <= 5; k++) begin
         step(); probe();
         chk("t4_err_early", m0_err, 0);
      end
      step(); probe();
      chk("t4_err", m0_err, 1);
      chk("t4_stb_forced", s_stb, 0);
      chk("t4_ack", m0_ack, 0);
      chk("t4z_err", z_m0_err, 0);
      chk("t4z_stb", z_s_stb, 1);
      step(); probe();
      chk("t4_err_pulse", m0_err, 0);
      chk("t4_stb_back", s_stb, 1);

      // Reset while m0 is granted with a strobe pending
      reset = 1;
      step(); reset = 0; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h50; probe();
      chk("t5_cyc", s_cyc, 0);
      chk("t5_err", m0_err, 0);
      chk("t5_ack", m0_ack, 0);
      step(); probe();
      chk("t5_tie_m0", s_adr, 32'h300);
      chk("t5_cyc_gnt", s_cyc, 1);
      step(); m0_cyc = 0; m0_stb = 0;
      step();
      step(); probe(); chk("t6_m1_adr", s_adr, 32'h50);
      step(); step();

      // Slave err on m1 clears the watchdog
      step(); s_err = 1; probe();
      chk("t6_err", m1_err, 1);
      chk("t6_ack", m1_ack, 0);
      chk("t6_m0_err", m0_err, 0);
      step(); s_err = 0; probe();
      chk("t6_after_err", m1_err, 0);
      for (int k = 2; k <= 5; k++) begin
         step(); probe();
         chk("t6_no_err", m1_err, 0);
      end
      // Timeout coincides with a slave ack: err wins
      step(); s_ack = 1; probe();
      chk("t7_err", m1_err, 1);
      chk("t7_ack_supp", m1_ack, 0);
      chk("t7_stb", s_stb, 0);
      chk("t7z_ack", z_m1_ack, 1);
      chk("t7z_err", z_m1_err, 0);
      step(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
      step(); step(); probe();
      chk("end_cyc", s_cyc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
